// File: rtl/octal_ram_burst_reader.sv
// Octal PSRAM linear-burst reader: sends the read command and address, waits out the
// read latency, then packs DQS-strobed rise/fall byte pairs into 16-bit upload FIFO writes.
module octal_ram_burst_reader #(
    parameter logic [7:0]  RD_CMD      = 8'h20,
    parameter int unsigned LATENCY_CYC = 6,
    parameter int unsigned BURST_WORDS = 1024,
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    input  logic [31:0] iAddr,
    output logic        oBusy,
    output logic        oPSRAM_CE,
    output logic [7:0]  oDq_P,
    output logic [7:0]  oDq_N,
    output logic        oDq_Oe,
    input  logic [7:0]  iDq_P,
    input  logic [7:0]  iDq_N,
    input  logic        iDqs_Vld,
    output logic        oFIFO_Wr_En,
    output logic [15:0] oFIFO_Wr_Data,
    input  logic        iFIFO_Full,
    output logic        oRdFrameDone,
    output logic        oOverflow,
    output logic        oTimeout
);

    localparam int unsigned LAT_W = (LATENCY_CYC > 1) ? $clog2(LATENCY_CYC + 1) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [LAT_W-1:0] LAST_LAT  = LAT_W'(LATENCY_CYC - 1);
    localparam logic [TO_W-1:0]  LAST_TO   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [15:0]      LAST_WORD = 16'(BURST_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_WAIT,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [TO_W-1:0]   to_q, to_d;

    logic              busy_q, busy_d;
    logic              ce_q, ce_d;
    logic              oe_q, oe_d;
    logic [7:0]        dq_p_q, dq_p_d;
    logic [7:0]        dq_n_q, dq_n_d;
    logic              wr_en_q, wr_en_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wcnt_d    = wcnt_q;
        lat_d     = lat_q;
        to_d      = to_q;
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_CMD;
                    addr_d  = iAddr;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            ST_CMD:     state_d = ST_ADDR_HI;
            ST_ADDR_HI: state_d = ST_ADDR_LO;
            ST_ADDR_LO: begin
                state_d = ST_WAIT;
                lat_d   = '0;
                to_d    = '0;
            end
            ST_WAIT: begin
                if (lat_q == LAST_LAT) begin
                    state_d = ST_DATA;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_DATA: begin
                // The PSRAM cannot be stalled: a full FIFO drops the word but still counts it.
                if (iDqs_Vld) begin
                    to_d   = '0;
                    wcnt_d = wcnt_q + 16'd1;
                    if (iFIFO_Full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {iDq_P, iDq_N};
                    end
                    if (wcnt_q == LAST_WORD) begin
                        state_d = ST_DONE;
                    end
                end else if (to_q == LAST_TO) begin
                    tmo_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Pad-facing outputs are decoded from the next state so they line up with state_q.
        ce_d   = 1'b1;
        oe_d   = 1'b0;
        dq_p_d = '0;
        dq_n_d = '0;
        case (state_d)
            ST_CMD: begin
                ce_d   = 1'b0;
                oe_d   = 1'b1;
                dq_p_d = RD_CMD;
                dq_n_d = RD_CMD;
            end
            ST_ADDR_HI: begin
                ce_d   = 1'b0;
                oe_d   = 1'b1;
                dq_p_d = addr_d[31:24];
                dq_n_d = addr_d[23:16];
            end
            ST_ADDR_LO: begin
                ce_d   = 1'b0;
                oe_d   = 1'b1;
                dq_p_d = addr_d[15:8];
                dq_n_d = addr_d[7:0];
            end
            ST_WAIT, ST_DATA: ce_d = 1'b0;
            default: ;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE) && !tmo_d;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wcnt_q    <= '0;
            lat_q     <= '0;
            to_q      <= '0;
            busy_q    <= 1'b0;
            ce_q      <= 1'b1;
            oe_q      <= 1'b0;
            dq_p_q    <= '0;
            dq_n_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wcnt_q    <= wcnt_d;
            lat_q     <= lat_d;
            to_q      <= to_d;
            busy_q    <= busy_d;
            ce_q      <= ce_d;
            oe_q      <= oe_d;
            dq_p_q    <= dq_p_d;
            dq_n_q    <= dq_n_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
        end
    end

    assign oBusy         = busy_q;
    assign oPSRAM_CE     = ce_q;
    assign oDq_Oe        = oe_q;
    assign oDq_P         = dq_p_q;
    assign oDq_N         = dq_n_q;
    assign oFIFO_Wr_En   = wr_en_q;
    assign oFIFO_Wr_Data = wr_data_q;
    assign oRdFrameDone  = done_q;
    assign oOverflow     = ovf_q;
    assign oTimeout      = tmo_q;

endmodule

// File: tb/tb_octal_ram_burst_reader.sv
// Randomized bench for octal_ram_burst_reader: a PSRAM read model feeds DQS pairs and
// queues expected FIFO writes; a negedge monitor pops and compares data and timing.
module tb_octal_ram_burst_reader;

    localparam int BW  = 8;
    localparam int LAT = 6;
    localparam int TO  = 32;
    localparam logic [7:0] TB_RD_CMD = 8'h20;

    logic        iClk;
    logic        iRst;
    logic        iStart;
    logic [31:0] iAddr;
    logic        oBusy;
    logic        oPSRAM_CE;
    logic [7:0]  oDq_P;
    logic [7:0]  oDq_N;
    logic        oDq_Oe;
    logic [7:0]  iDq_P;
    logic [7:0]  iDq_N;
    logic        iDqs_Vld;
    logic        oFIFO_Wr_En;
    logic [15:0] oFIFO_Wr_Data;
    logic        iFIFO_Full;
    logic        oRdFrameDone;
    logic        oOverflow;
    logic        oTimeout;

    octal_ram_burst_reader #(
        .RD_CMD      (TB_RD_CMD),
        .LATENCY_CYC (LAT),
        .BURST_WORDS (BW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iStart        (iStart),
        .iAddr         (iAddr),
        .oBusy         (oBusy),
        .oPSRAM_CE     (oPSRAM_CE),
        .oDq_P         (oDq_P),
        .oDq_N         (oDq_N),
        .oDq_Oe        (oDq_Oe),
        .iDq_P         (iDq_P),
        .iDq_N         (iDq_N),
        .iDqs_Vld      (iDqs_Vld),
        .oFIFO_Wr_En   (oFIFO_Wr_En),
        .oFIFO_Wr_Data (oFIFO_Wr_Data),
        .iFIFO_Full    (iFIFO_Full),
        .oRdFrameDone  (oRdFrameDone),
        .oOverflow     (oOverflow),
        .oTimeout      (oTimeout)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every FIFO write must match the oldest expected word, one cycle after its DQS.
    always @(negedge iClk) begin
        if (oFIFO_Wr_En) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write actual=%0h required=none (t=%0t)", oFIFO_Wr_Data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_data", oFIFO_Wr_Data, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
        if (oRdFrameDone) done_cnt++;
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // One read burst from the PSRAM side. gap_mode: 0 back-to-back, 1 random 0-2, 2 three-cycle
    // gaps before words 3 and 5. Words full_lo..full_hi see a full FIFO. rst_at >= 0 resets mid-DATA.
    task automatic run_burst(input logic [31:0] addr, input int nsend, input int gap_mode,
                             input int full_lo, input int full_hi, input bit glitch, input int rst_at);
        int done0;
        int gap;
        bit full;
        bit exp_ovf;
        bit aborted;
        logic [7:0] p;
        logic [7:0] n;
        exp_t e;
        done0   = done_cnt;
        exp_ovf = 1'b0;
        aborted = 1'b0;

        step();
        iStart = 1'b1;
        iAddr  = addr;
        step();
        iStart = 1'b0;
        iAddr  = $urandom;
        chk("cmd_busy", oBusy, 1);
        chk("cmd_ce", oPSRAM_CE, 0);
        chk("cmd_oe", oDq_Oe, 1);
        chk("cmd_p", oDq_P, TB_RD_CMD);
        chk("cmd_n", oDq_N, TB_RD_CMD);
        chk("cmd_ovf_cleared", oOverflow, 0);
        chk("cmd_tmo_cleared", oTimeout, 0);
        step();
        chk("addr0_p", oDq_P, addr[31:24]);
        chk("addr0_n", oDq_N, addr[23:16]);
        chk("addr0_oe", oDq_Oe, 1);
        step();
        chk("addr1_p", oDq_P, addr[15:8]);
        chk("addr1_n", oDq_N, addr[7:0]);
        chk("addr1_oe", oDq_Oe, 1);

        // Latency window: junk strobes here must never reach the FIFO.
        for (int i = 0; i < LAT; i++) begin
            step();
            chk("wait_oe", oDq_Oe, 0);
            chk("wait_ce", oPSRAM_CE, 0);
            iDqs_Vld = 1'b1;
            iDq_P    = 8'($urandom);
            iDq_N    = 8'($urandom);
            iStart   = glitch && (i == 2);
        end
        step();
        iDqs_Vld = 1'b0;
        iStart   = 1'b0;

        for (int w = 0; w < nsend && !aborted; w++) begin
            if (gap_mode == 1)                        gap = int'($urandom_range(2, 0));
            else if (gap_mode == 2 && (w == 3 || w == 5)) gap = 3;
            else                                      gap = 0;
            iDqs_Vld = 1'b0;
            repeat (gap) step();
            p    = 8'($urandom);
            n    = 8'($urandom);
            full = (w >= full_lo) && (w <= full_hi);
            iDqs_Vld   = 1'b1;
            iDq_P      = p;
            iDq_N      = n;
            iFIFO_Full = full;
            iStart     = glitch && (w == 2);
            if (full) begin
                exp_ovf = 1'b1;
            end else begin
                e.data = {p, n};
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
            end
            step();
            iDqs_Vld   = 1'b0;
            iFIFO_Full = 1'b0;
            iStart     = 1'b0;
            if (w == rst_at) begin
                chk("pre_rst_ce", oPSRAM_CE, 0);
                @(negedge iClk);
                #2;
                iRst = 1'b1;
                #1;
                chk("rst_async_ce", oPSRAM_CE, 1);
                chk("rst_async_oe", oDq_Oe, 0);
                chk("rst_async_busy", oBusy, 0);
                chk("rst_writes_flushed", exp_q.size(), 0);
                exp_q.delete();
                #20;
                iRst = 1'b0;
                chk("rst_no_done", done_cnt - done0, 0);
                aborted = 1'b1;
            end
        end

        if (!aborted) begin
            if (nsend >= BW) begin
                chk("done_pulse", oRdFrameDone, 1);
                chk("done_ce", oPSRAM_CE, 1);
                chk("done_busy", oBusy, 1);
                step();
                chk("idle_busy", oBusy, 0);
                chk("idle_done", oRdFrameDone, 0);
            end else begin
                for (int k = 0; k < TO; k++) begin
                    chk("to_pending", oTimeout, 0);
                    chk("to_pending_ce", oPSRAM_CE, 0);
                    step();
                end
                chk("to_flag", oTimeout, 1);
                chk("to_ce", oPSRAM_CE, 1);
                chk("to_no_done", oRdFrameDone, 0);
                step();
                chk("to_idle_busy", oBusy, 0);
                chk("to_sticky", oTimeout, 1);
            end
            chk("all_words_written", exp_q.size(), 0);
            chk("overflow_flag", oOverflow, exp_ovf);
            chk("timeout_flag", oTimeout, (nsend < BW));
            chk("done_count", done_cnt - done0, (nsend >= BW));
            if (glitch) begin
                repeat (3) step();
                chk("no_second_burst", oBusy, 0);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iRst       = 1'b1;
        iStart     = 1'b0;
        iAddr      = '0;
        iDq_P      = '0;
        iDq_N      = '0;
        iDqs_Vld   = 1'b0;
        iFIFO_Full = 1'b0;
        #13;
        chk("rst_ce", oPSRAM_CE, 1);
        chk("rst_oe", oDq_Oe, 0);
        chk("rst_p", oDq_P, 0);
        chk("rst_n", oDq_N, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_wr_en", oFIFO_Wr_En, 0);
        chk("rst_wr_data", oFIFO_Wr_Data, 0);
        chk("rst_done", oRdFrameDone, 0);
        chk("rst_ovf", oOverflow, 0);
        chk("rst_tmo", oTimeout, 0);
        #9;
        iRst = 1'b0;

        run_burst(32'h0000_1000, BW, 0, 99, -1, 1'b0, -1);
        run_burst($urandom, BW, 2, 99, -1, 1'b0, -1);
        run_burst($urandom, BW, 0, 2, 3, 1'b0, -1);
        run_burst($urandom, 5, 1, 99, -1, 1'b0, -1);
        run_burst($urandom, BW, 1, 99, -1, 1'b0, 3);
        run_burst(32'h0000_1000, BW, 0, 99, -1, 1'b0, -1);
        run_burst($urandom, BW, 1, 99, -1, 1'b1, -1);
        for (int r = 0; r < 4; r++) begin
            int lo;
            lo = int'($urandom_range(BW - 1, 0));
            run_burst($urandom, BW, 1, lo, lo + int'($urandom_range(2, 0)), 1'b0, -1);
        end
        run_burst($urandom, BW - 1, 1, 0, 0, 1'b0, -1);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
